// File: rtl/tag_compare_mw_if.sv
// Bundle of R-channel, request/write-buffer queues and downstream miss/hit queue signals
// for tag_compare_mw. The comparator is the master side; the surrounding queues are the slave side.
interface tag_compare_mw_if #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 512,
    parameter int TID_WIDTH    = 4,
    parameter int WAYS         = 2,
    parameter int INDEX_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 6,
    parameter int ID_WIDTH     = 4
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [ID_WIDTH-1:0]                        rid_i;
    logic [WAYS*(TAG_WIDTH+2)-1:0]              rtag_i;
    logic [WAYS*DATA_WIDTH-1:0]                 rdata_i;
    logic                                       rvalid_i;
    logic                                       rready_o;
    logic                                       tag_fifo_aempty_i;
    logic                                       tag_fifo_rden_o;
    logic [TID_WIDTH+ADDR_WIDTH:0]              tag_fifo_data_i;
    logic                                       wbuffer_aempty_i;
    logic                                       wbuffer_rden_o;
    logic [DATA_WIDTH-1:0]                      wbuffer_data_i;
    logic                                       rob_afull_i;
    logic                                       rob_wren_o;
    logic [TID_WIDTH+DATA_WIDTH-1:0]            rob_data_o;
    logic                                       ar_fifo_afull_i;
    logic                                       ar_fifo_wren_o;
    logic [WAY_W+TID_WIDTH+ADDR_WIDTH-1:0]      ar_fifo_data_o;
    logic                                       aw_fifo_afull_i;
    logic                                       aw_fifo_wren_o;
    logic [ADDR_WIDTH-1:0]                      aw_fifo_data_o;
    logic                                       w_fifo_afull_i;
    logic                                       w_fifo_wren_o;
    logic [DATA_WIDTH-1:0]                      w_fifo_data_o;
    logic                                       fill_ready_i;
    logic                                       fill_valid_o;
    logic [WAY_W+ADDR_WIDTH+DATA_WIDTH-1:0]     fill_data_o;
    logic                                       multihit_o;

    modport master (
        input  rid_i, rtag_i, rdata_i, rvalid_i,
        input  tag_fifo_aempty_i, tag_fifo_data_i, wbuffer_aempty_i, wbuffer_data_i,
        input  rob_afull_i, ar_fifo_afull_i, aw_fifo_afull_i, w_fifo_afull_i, fill_ready_i,
        output rready_o, tag_fifo_rden_o, wbuffer_rden_o,
        output rob_wren_o, rob_data_o, ar_fifo_wren_o, ar_fifo_data_o,
        output aw_fifo_wren_o, aw_fifo_data_o, w_fifo_wren_o, w_fifo_data_o,
        output fill_valid_o, fill_data_o, multihit_o
    );

    modport slave (
        output rid_i, rtag_i, rdata_i, rvalid_i,
        output tag_fifo_aempty_i, tag_fifo_data_i, wbuffer_aempty_i, wbuffer_data_i,
        output rob_afull_i, ar_fifo_afull_i, aw_fifo_afull_i, w_fifo_afull_i, fill_ready_i,
        input  rready_o, tag_fifo_rden_o, wbuffer_rden_o,
        input  rob_wren_o, rob_data_o, ar_fifo_wren_o, ar_fifo_data_o,
        input  aw_fifo_wren_o, aw_fifo_data_o, w_fifo_wren_o, w_fifo_data_o,
        input  fill_valid_o, fill_data_o, multihit_o
    );
endinterface

// File: rtl/tag_compare_mw.sv
// Multi-way DRAM-cache tag comparator: hit/miss resolution, victim choice, dirty writeback.
// Define TAG_COMPARE_STATS_EN to add 32-bit saturating outcome counters.
module tag_compare_mw #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 512,
    parameter int TID_WIDTH    = 4,
    parameter int WAYS         = 2,
    parameter int INDEX_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 6,
    parameter int ID_WIDTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TAG_COMPARE_STATS_EN
    output logic [31:0] rhit_cnt_o,
    output logic [31:0] rmiss_cnt_o,
    output logic [31:0] whit_cnt_o,
    output logic [31:0] wmiss_cnt_o,
    output logic [31:0] wb_cnt_o,
`endif
    tag_compare_mw_if.master bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [2:0] {IDLE, RHIT, RMISS, WHIT, WMISS} state_t;
    state_t state_q, state_d;

    logic [WAYS-1:0][TAG_WIDTH+1:0]  ent;
    logic [WAYS-1:0][DATA_WIDTH-1:0] line;
    assign ent  = bus.rtag_i;
    assign line = bus.rdata_i;

    logic                  req_wr;
    logic [TID_WIDTH-1:0]  req_tid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]  req_tag;
    assign {req_wr, req_tid, req_addr} = bus.tag_fifo_data_i;
    assign req_tag = req_addr[ADDR_WIDTH-1:TAG_LSB];

    logic unused_rid;
    assign unused_rid = ^bus.rid_i;

    logic [WAYS-1:0] way_valid, way_dirty, way_hit;
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_valid[w] = ent[w][TAG_WIDTH+1];
        assign way_dirty[w] = ent[w][TAG_WIDTH];
        assign way_hit[w]   = way_valid[w] && (ent[w][TAG_WIDTH-1:0] == req_tag);
    end

    // Lowest index wins for both the hit way and the invalid-way victim.
    logic [WAY_W-1:0] hit_way, inv_way, victim, rr_ptr_q;
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])    hit_way = WAY_W'(w);
            if (!way_valid[w]) inv_way = WAY_W'(w);
        end
    end

    logic hit_any, inv_any, multi, wb, accept, wb_q, res_ok;
    assign hit_any = |way_hit;
    assign inv_any = ~&way_valid;
    assign multi   = $countones(way_hit) > 1;
    assign victim  = inv_any ? inv_way : rr_ptr_q;
    assign wb      = way_valid[victim] && way_dirty[victim];
    assign accept  = !rst && (state_q == IDLE) && bus.rvalid_i && !bus.tag_fifo_aempty_i &&
                     (!req_wr || !bus.wbuffer_aempty_i);
    assign res_ok  = !wb_q || (!bus.aw_fifo_afull_i && !bus.w_fifo_afull_i);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = req_wr ? (hit_any ? WHIT : WMISS) : (hit_any ? RHIT : RMISS);
            RHIT:  if (!bus.rob_afull_i) state_d = IDLE;
            RMISS: if (!bus.ar_fifo_afull_i && res_ok) state_d = IDLE;
            WHIT:  if (bus.fill_ready_i) state_d = IDLE;
            WMISS: if (bus.fill_ready_i && res_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every strobe is forced low while rst is high, including the reset cycle itself.
    logic rmiss_go, wmiss_go;
    always_comb begin
        bus.rready_o        = accept;
        bus.tag_fifo_rden_o = accept;
        bus.wbuffer_rden_o  = accept && req_wr;
        bus.rob_wren_o      = 1'b0;
        bus.ar_fifo_wren_o  = 1'b0;
        bus.aw_fifo_wren_o  = 1'b0;
        bus.w_fifo_wren_o   = 1'b0;
        bus.fill_valid_o    = 1'b0;
        rmiss_go            = !bus.ar_fifo_afull_i && res_ok;
        wmiss_go            = bus.fill_ready_i && res_ok;
        if (!rst) begin
            case (state_q)
                RHIT:  bus.rob_wren_o = !bus.rob_afull_i;
                RMISS: begin
                    bus.ar_fifo_wren_o = rmiss_go;
                    bus.aw_fifo_wren_o = rmiss_go && wb_q;
                    bus.w_fifo_wren_o  = rmiss_go && wb_q;
                end
                WHIT:  bus.fill_valid_o = 1'b1;
                WMISS: begin
                    bus.fill_valid_o   = 1'b1;
                    bus.aw_fifo_wren_o = wmiss_go && wb_q;
                    bus.w_fifo_wren_o  = wmiss_go && wb_q;
                end
                default: ;
            endcase
        end
    end

    logic [TID_WIDTH+DATA_WIDTH-1:0]        rob_data_q;
    logic [WAY_W+TID_WIDTH+ADDR_WIDTH-1:0]  ar_data_q;
    logic [ADDR_WIDTH-1:0]                  aw_data_q;
    logic [DATA_WIDTH-1:0]                  w_data_q;
    logic [WAY_W+ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_q;
    logic                                   multihit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wb_q        <= 1'b0;
            multihit_q  <= 1'b0;
            rob_data_q  <= '0;
            ar_data_q   <= '0;
            aw_data_q   <= '0;
            w_data_q    <= '0;
            fill_data_q <= '0;
        end else if (accept) begin
            if (multi) multihit_q <= 1'b1;
            if (!hit_any && !inv_any) rr_ptr_q <= (WAYS > 1) ? rr_ptr_q + 1'b1 : '0;
            wb_q <= !hit_any && wb;
            if (!req_wr && hit_any)  rob_data_q <= {req_tid, line[hit_way]};
            if (!req_wr && !hit_any) ar_data_q  <= {victim, req_tid, req_addr};
            if (!hit_any && wb) begin
                aw_data_q <= {ent[victim][TAG_WIDTH-1:0], req_addr[TAG_LSB-1:OFFSET_WIDTH],
                              {OFFSET_WIDTH{1'b0}}};
                w_data_q  <= line[victim];
            end
            if (req_wr) fill_data_q <= {hit_any ? hit_way : victim, req_addr, bus.wbuffer_data_i};
        end
    end

    assign bus.rob_data_o     = rob_data_q;
    assign bus.ar_fifo_data_o = ar_data_q;
    assign bus.aw_fifo_data_o = aw_data_q;
    assign bus.w_fifo_data_o  = w_data_q;
    assign bus.fill_data_o    = fill_data_q;
    assign bus.multihit_o     = multihit_q;

`ifdef TAG_COMPARE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] rhit_q, rmiss_q, whit_q, wmiss_q, wbc_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rhit_q  <= '0;
            rmiss_q <= '0;
            whit_q  <= '0;
            wmiss_q <= '0;
            wbc_q   <= '0;
        end else begin
            rhit_q  <= sat_inc(rhit_q,  accept && !req_wr && hit_any);
            rmiss_q <= sat_inc(rmiss_q, accept && !req_wr && !hit_any);
            whit_q  <= sat_inc(whit_q,  accept && req_wr && hit_any);
            wmiss_q <= sat_inc(wmiss_q, accept && req_wr && !hit_any);
            wbc_q   <= sat_inc(wbc_q,   accept && !hit_any && wb);
        end
    end
    assign rhit_cnt_o  = rhit_q;
    assign rmiss_cnt_o = rmiss_q;
    assign whit_cnt_o  = whit_q;
    assign wmiss_cnt_o = wmiss_q;
    assign wb_cnt_o    = wbc_q;
`endif
endmodule

// File: doc/tag_compare_mw.md
# tag_compare_mw

Multi-way successor of the direct-mapped DRAM-cache tag comparator. It sits between the memory-controller R channel and the miss/hit queues (ROB, AR/AW/W FIFOs, fill arbiter) and resolves one request per lookup against `WAYS` tag/data pairs read from DRAM. Unlike the direct-mapped block, it does the following:
- selects a victim way;
- writes back only valid-and-dirty victims;
- gates writes on write-buffer availability;
- flags multi-hit corruption.

## Interface
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 512, cache line width
- TID_WIDTH, 4, transaction id width
- WAYS, 2, associativity (power of two, 1..8); WAY_W = max(1, $clog2(WAYS))
- INDEX_WIDTH, 16, set index bits
- OFFSET_WIDTH, 6, line offset bits; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
- ID_WIDTH, 4, AXI id width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rid_i  in  ID_WIDTH  R id, ignored
- rtag_i  in  WAYS*(TAG_WIDTH+2)  per way {valid, dirty, tag}, way 0 in LSBs
- rdata_i  in  WAYS*DATA_WIDTH  per way line, way 0 in LSBs
- rvalid_i / rready_o  in/out  1  R handshake
- tag_fifo_aempty_i / tag_fifo_rden_o / tag_fifo_data_i  in/out/in  1/1/1+TID_WIDTH+ADDR_WIDTH  request {wr, tid, addr}
- wbuffer_aempty_i / wbuffer_rden_o / wbuffer_data_i  in/out/in  1/1/DATA_WIDTH  write data
- rob_afull_i / rob_wren_o / rob_data_o  in/out/out  1/1/TID_WIDTH+DATA_WIDTH  read hit {tid, data}
- ar_fifo_afull_i / ar_fifo_wren_o / ar_fifo_data_o  in/out/out  1/1/WAY_W+TID_WIDTH+ADDR_WIDTH  read miss {way, tid, addr}
- aw_fifo_afull_i / aw_fifo_wren_o / aw_fifo_data_o  in/out/out  1/1/ADDR_WIDTH  victim writeback address
- w_fifo_afull_i / w_fifo_wren_o / w_fifo_data_o  in/out/out  1/1/DATA_WIDTH  victim data
- fill_ready_i / fill_valid_o / fill_data_o  in/out/out  1/1/WAY_W+ADDR_WIDTH+DATA_WIDTH  write {way, addr, data}
- multihit_o  out  1  sticky: more than one way matched

## Operation
- **States:** IDLE, RHIT, RMISS, WHIT, WMISS.
- **Accept condition in IDLE:** rvalid_i & !tag_fifo_aempty_i & (read | !wbuffer_aempty_i).
  - On accept, pulse rready_o and tag_fifo_rden_o for one cycle; writes also pulse wbuffer_rden_o.
  - All payloads are registered on accept.
- **Hit:** way i has valid & (tag == addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH]).
  - If several ways hit, the lowest index is used and multihit_o is set until reset.
- **Victim on miss:**
  - The lowest-index invalid way is chosen.
  - If no way is invalid, the victim is rr_ptr, and rr_ptr increments modulo WAYS on that accept.
- **Writeback:** wb = victim valid & dirty. The writeback address is {victim tag, addr index, OFFSET_WIDTH'0}.
- **Read hit:** go to RHIT; rob_data = {tid, hit line}.
- **Read miss:** go to RMISS; ar_fifo_data = {victim, tid, addr}; AW/W are loaded only when wb.
- **Write hit:** go to WHIT; fill_data = {hit way, addr, wbuffer data}.
- **Write miss:** go to WMISS; fill_data = {victim, addr, wbuffer data}; AW/W are loaded only when wb.
- **RHIT:** rob_wren_o = !rob_afull_i; on write, go to IDLE.
- **RMISS:**
  - The required resources are ar_fifo and, if wb, aw_fifo and w_fifo.
  - All required wrens assert in the same cycle, only when none of the required FIFOs is afull; then go to IDLE.
- **WHIT:** fill_valid_o is held until fill_ready_i, then go to IDLE.
- **WMISS:**
  - fill_valid_o is held.
  - Completion requires fill_ready_i and, if wb, !aw_fifo_afull_i & !w_fifo_afull_i.
  - AW/W wrens assert only in the completion cycle; then go to IDLE.
- **Clean victim:** no AW/W write is ever issued.

## Timing
- **Reset values:** every output is 0, state is IDLE, rr_ptr is 0, multihit_o is 0, and all payload registers are 0.
- **Reset mid-operation:** reset asserted in any state discards the registered request; no wren pulses in the reset cycle or after it.
- **Latency:** accept in cycle N; the earliest downstream write is cycle N+1.
- **Throughput:** maximum 1 request per 2 cycles; no accept occurs outside IDLE.
- **Data stability:** payload outputs are stable from entry to exit of an issue state; wren pulses last exactly one cycle.
- **Handshakes:** rready_o is never asserted without tag_fifo_rden_o in the same cycle.
- **Empty queues:** a write with wbuffer_aempty_i stalls in IDLE without asserting rready_o.
- **WAYS=1:** the victim is always way 0 and rr_ptr is constant.

## Configuration
- `TAG_COMPARE_STATS_EN` defined: 32-bit saturating counters are added, with ports out 32 each, cleared by rst:
  - rhit_cnt_o, rmiss_cnt_o, whit_cnt_o, wmiss_cnt_o, wb_cnt_o.
  - Each increments on the accept cycle of the matching outcome; wb_cnt_o increments when wb is set.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- WAYS=2; way1 {v=1,d=0,tag=0x1234}; read tid=3 of tag 0x1234 -> one rob_wren_o at N+1 with {3, way1 line}; no AR/AW/W activity.
- Both ways valid and dirty, rr_ptr=0; read miss -> ar_fifo_data {0, tid, addr}; aw addr = way0 tag|index|0; w = way0 line; all three wrens in the same cycle; rr_ptr becomes 1.
- Write miss, way0 invalid -> fill_data way=0; no AW/W write; fill_valid_o held for 3 cycles of fill_ready_i=0, then exits.
- RMISS with dirty victim and w_fifo_afull_i=1 for 4 cycles -> no wren for 4 cycles, then all wrens together.
- Both ways valid with the same matching tag -> way0 is used; multihit_o=1 and stays 1; cleared only by rst.
- rst asserted while in WMISS -> all outputs 0 the next cycle; no fill or AW write afterwards.
